// File: rtl/avalon_st_pkt_arbiter.sv
// Avalon-ST packet arbiter: round-robin choice among NUM_IN sinks, with the grant
// locked from the first beat of a packet until its end-of-packet beat is accepted.
module avalon_st_pkt_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int ERR_W   = 1,
  parameter int CH_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic [NUM_IN*ERR_W-1:0]   in_error,
  input  logic [NUM_IN-1:0]         in_startofpacket,
  input  logic [NUM_IN-1:0]         in_endofpacket,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [ERR_W-1:0]          out_error,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [CH_W-1:0]           out_channel,
  output logic [15:0]               pkt_count
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PKT = 1'b1} state_t;

  state_t          r_state;
  logic [CH_W-1:0] r_grant;
  logic [CH_W-1:0] r_rr_ptr;
  logic [15:0]     r_pkt_count;

  logic            w_found;
  logic [CH_W-1:0] w_pick;
  logic            w_active;
  logic            w_done;

  // Sink index base+offset, wrapped into 0..NUM_IN-1 (offset never exceeds NUM_IN).
  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    sum = (sum >= NUM_IN) ? (sum - NUM_IN) : sum;
    return CH_W'(sum);
  endfunction

  // Outputs are also gated by reset so nothing leaks through while it is asserted.
  assign w_active  = (r_state == S_PKT) && !reset;
  assign w_done    = w_active && in_valid[r_grant] && out_ready && in_endofpacket[r_grant];
  assign pkt_count = r_pkt_count;

  // Round-robin search: first valid sink at or above rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = {CH_W{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_found && in_valid[rr_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(r_rr_ptr, k);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Grant FSM, round-robin pointer and packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= {CH_W{1'b0}};
      r_rr_ptr    <= {CH_W{1'b0}};
      r_pkt_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_PKT;
          end
        end
        S_PKT: begin
          if (w_done) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= rr_idx(r_grant, 1);
            r_pkt_count <= r_pkt_count + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Source port mirrors the granted sink; only that sink sees ready.
  always_comb begin
    out_valid         = 1'b0;
    out_data          = {DATA_W{1'b0}};
    out_empty         = {EMPTY_W{1'b0}};
    out_error         = {ERR_W{1'b0}};
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_channel       = {CH_W{1'b0}};
    in_ready          = {NUM_IN{1'b0}};
    if (w_active) begin
      out_valid         = in_valid[r_grant];
      out_data          = in_data[int'(r_grant)*DATA_W +: DATA_W];
      out_empty         = in_empty[int'(r_grant)*EMPTY_W +: EMPTY_W];
      out_error         = in_error[int'(r_grant)*ERR_W +: ERR_W];
      out_startofpacket = in_startofpacket[r_grant];
      out_endofpacket   = in_endofpacket[r_grant];
      out_channel       = r_grant;
      in_ready[r_grant] = out_ready;
    end else begin
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Directed bench for avalon_st_pkt_arbiter: each scenario drives sinks at the falling
// edge and checks the combinational source port one time unit later.
module tb_avalon_st_pkt_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid, in_ready, in_sop, in_eop, in_error;
  logic [127:0] in_data;
  logic [7:0]  in_empty;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [31:0] out_data;
  logic [1:0]  out_empty, out_channel;
  logic [0:0]  out_error;
  logic [15:0] pkt_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_count;
  logic bp_mon = 1'b0;
  logic [31:0] bp_log [$];

  avalon_st_pkt_arbiter #(.NUM_IN(4), .DATA_W(32), .EMPTY_W(2), .ERR_W(1), .CH_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_empty(in_empty),
    .in_error(in_error), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_empty(out_empty),
    .out_error(out_error), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
    .out_channel(out_channel), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Records every beat the source hands off, sampled mid-cycle.
  always begin
    @(negedge clk);
    #2;
    if (bp_mon && out_valid && out_ready) bp_log.push_back(out_data);
  end

  task automatic drive(input int i, input logic v, input logic [31:0] d, input logic s, input logic e);
    in_valid[i]        = v;
    in_data[i*32 +: 32] = d;
    in_sop[i]          = s;
    in_eop[i]          = e;
    in_empty[i*2 +: 2] = i[1:0];
    in_error[i]        = 1'b0;
  endtask

  task automatic clear_all();
    in_valid = 4'b0000; in_sop = 4'b0000; in_eop = 4'b0000; in_error = 4'b0000;
    in_data = 128'd0; in_empty = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; clear_all();
    drive(1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_channel !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b ready=%b ch=%0d exp 0/0000/0", out_valid, in_ready, out_channel);
    end
    @(negedge clk); reset = 1'b0; clear_all(); #1;
    exp_count = 16'd0;
    checks++;
    if (pkt_count !== exp_count || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_count got count=%h valid=%b exp %h/0", pkt_count, out_valid, exp_count);
    end
  endtask

  task automatic test_single_pkt();
    @(negedge clk); drive(2, 1'b1, 32'h1111_0001, 1'b1, 1'b0); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      failures++; $display("FAIL single_idle got valid=%b ready=%b exp 0/0000", out_valid, in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd2 || out_data !== 32'h1111_0001 || out_sop !== 1'b1
        || in_ready !== 4'b0100 || out_empty !== 2'd2) begin
      failures++;
      $display("FAIL single_beat1 got v=%b ch=%0d d=%h sop=%b rdy=%b emp=%0d exp 1/2/11110001/1/0100/2",
               out_valid, out_channel, out_data, out_sop, in_ready, out_empty);
    end
    @(negedge clk); drive(2, 1'b1, 32'h1111_0002, 1'b0, 1'b0); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1111_0002 || out_eop !== 1'b0) begin
      failures++; $display("FAIL single_beat2 got v=%b d=%h eop=%b exp 1/11110002/0", out_valid, out_data, out_eop);
    end
    @(negedge clk); drive(2, 1'b1, 32'h1111_0003, 1'b0, 1'b1); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1111_0003 || out_eop !== 1'b1 || out_channel !== 2'd2) begin
      failures++; $display("FAIL single_beat3 got v=%b d=%h eop=%b ch=%0d exp 1/11110003/1/2", out_valid, out_data, out_eop, out_channel);
    end
    @(negedge clk); clear_all(); #1;
    exp_count = 16'd1;
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== exp_count) begin
      failures++; $display("FAIL single_done got v=%b count=%h exp 0/%h", out_valid, pkt_count, exp_count);
    end
    // Pointer now at 3: with sinks 0 and 3 competing, 3 must win.
    drive(0, 1'b1, 32'h2222_0000, 1'b1, 1'b1);
    drive(3, 1'b1, 32'h2222_0003, 1'b1, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (out_channel !== 2'd3 || out_data !== 32'h2222_0003 || in_ready !== 4'b1000) begin
      failures++; $display("FAIL rr_ptr_after_2 got ch=%0d d=%h rdy=%b exp 3/22220003/1000", out_channel, out_data, in_ready);
    end
    @(negedge clk); clear_all(); #1;
    exp_count = 16'd2;
    checks++;
    if (pkt_count !== exp_count) begin
      failures++; $display("FAIL rr_ptr_count got %h exp %h", pkt_count, exp_count);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [0:4];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 32'h0000_00A0 + i, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (k % 2 == 0) begin
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL rr_idle_gap k=%0d got valid=%b exp 0", k, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_channel !== order[k/2]
                   || out_data !== (32'h0000_00A0 + 32'(order[k/2]))) begin
        failures++;
        $display("FAIL rr_order k=%0d got v=%b ch=%0d d=%h exp ch=%0d", k, out_valid, out_channel, out_data, order[k/2]);
      end
    end
    @(negedge clk); clear_all(); #1;
    exp_count = exp_count + 16'd5;
    checks++;
    if (pkt_count !== exp_count) begin
      failures++; $display("FAIL rr_count got %h exp %h", pkt_count, exp_count);
    end
  endtask

  task automatic test_hold_off();
    @(negedge clk); drive(1, 1'b1, 32'h3333_0001, 1'b1, 1'b0);
    @(negedge clk); drive(0, 1'b1, 32'h3333_00F0, 1'b1, 1'b1); #1;
    checks++;
    if (out_channel !== 2'd1 || in_ready !== 4'b0010) begin
      failures++; $display("FAIL hold_beat1 got ch=%0d rdy=%b exp 1/0010", out_channel, in_ready);
    end
    @(negedge clk); drive(1, 1'b1, 32'h3333_0002, 1'b0, 1'b0); #1;
    checks++;
    if (in_ready !== 4'b0010 || out_data !== 32'h3333_0002) begin
      failures++; $display("FAIL hold_beat2 got rdy=%b d=%h exp 0010/33330002", in_ready, out_data);
    end
    @(negedge clk); drive(1, 1'b1, 32'h3333_0003, 1'b0, 1'b1); #1;
    checks++;
    if (in_ready !== 4'b0010 || out_eop !== 1'b1) begin
      failures++; $display("FAIL hold_beat3 got rdy=%b eop=%b exp 0010/1", in_ready, out_eop);
    end
    @(negedge clk); drive(1, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      failures++; $display("FAIL hold_idle got v=%b rdy=%b exp 0/0000", out_valid, in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd0 || out_data !== 32'h3333_00F0 || in_ready !== 4'b0001) begin
      failures++; $display("FAIL hold_next_grant got v=%b ch=%0d d=%h rdy=%b exp 1/0/333300f0/0001",
                           out_valid, out_channel, out_data, in_ready);
    end
    @(negedge clk); clear_all(); #1;
    exp_count = exp_count + 16'd2;
    checks++;
    if (pkt_count !== exp_count) begin
      failures++; $display("FAIL hold_count got %h exp %h", pkt_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    bp_log.delete();
    bp_mon = 1'b1;
    @(negedge clk); drive(2, 1'b1, 32'h4444_0001, 1'b1, 1'b0); out_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (out_channel !== 2'd2 || out_data !== 32'h4444_0001) begin
      failures++; $display("FAIL bp_beat1 got ch=%0d d=%h exp 2/44440001", out_channel, out_data);
    end
    @(negedge clk); drive(2, 1'b0, 32'h4444_00EE, 1'b0, 1'b0); #1;
    checks++;
    if (out_valid !== 1'b0 || out_channel !== 2'd2) begin
      failures++; $display("FAIL bp_valid_gap got v=%b ch=%0d exp 0/2", out_valid, out_channel);
    end
    @(negedge clk); drive(2, 1'b1, 32'h4444_0002, 1'b0, 1'b0); out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h4444_0002 || in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_stall c=%0d got v=%b d=%h rdy=%b exp 1/44440002/0000", c, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 4'b0100 || out_data !== 32'h4444_0002) begin
      failures++; $display("FAIL bp_release got rdy=%b d=%h exp 0100/44440002", in_ready, out_data);
    end
    @(negedge clk); drive(2, 1'b1, 32'h4444_0003, 1'b0, 1'b1);
    @(negedge clk); clear_all(); #3;
    bp_mon = 1'b0;
    exp_count = exp_count + 16'd1;
    checks++;
    if (bp_log.size() != 3) begin
      failures++; $display("FAIL bp_beat_count got %0d exp 3", bp_log.size());
    end else if (bp_log[0] !== 32'h4444_0001 || bp_log[1] !== 32'h4444_0002 || bp_log[2] !== 32'h4444_0003) begin
      failures++; $display("FAIL bp_beat_seq got %h %h %h exp 44440001 44440002 44440003", bp_log[0], bp_log[1], bp_log[2]);
    end
    checks++;
    if (pkt_count !== exp_count) begin
      failures++; $display("FAIL bp_count got %h exp %h", pkt_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1, 1'b1, 32'h5555_0001, 1'b1, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (out_channel !== 2'd1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_grant got ch=%0d v=%b exp 1/1", out_channel, out_valid);
    end
    @(negedge clk); drive(1, 1'b1, 32'h5555_0002, 1'b0, 1'b0); reset = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_during got v=%b rdy=%b exp 0/0000", out_valid, in_ready);
    end
    @(negedge clk); reset = 1'b0; clear_all(); drive(3, 1'b1, 32'h5555_0030, 1'b1, 1'b1); #1;
    exp_count = 16'd0;
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== exp_count || out_channel !== 2'd0) begin
      failures++; $display("FAIL rst_mid_after got v=%b count=%h ch=%0d exp 0/%h/0", out_valid, pkt_count, out_channel, exp_count);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd3 || out_data !== 32'h5555_0030) begin
      failures++; $display("FAIL rst_mid_new_grant got v=%b ch=%0d d=%h exp 1/3/55550030", out_valid, out_channel, out_data);
    end
    @(negedge clk); clear_all(); #1;
    exp_count = 16'd1;
    checks++;
    if (pkt_count !== exp_count) begin
      failures++; $display("FAIL rst_mid_count got %h exp %h", pkt_count, exp_count);
    end
  endtask

  task automatic send_one(input int i, input logic [31:0] d);
    @(negedge clk); drive(i, 1'b1, d, 1'b1, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'(i) || out_data !== d) begin
      failures++; $display("FAIL send_one got v=%b ch=%0d d=%h exp 1/%0d/%h", out_valid, out_channel, out_data, i, d);
    end
    @(negedge clk); clear_all(); #1;
  endtask

  task automatic test_wrap();
    @(negedge clk); force dut.r_pkt_count = 16'hFFFE;
    @(negedge clk); release dut.r_pkt_count;
    send_one(0, 32'h6666_0000);
    checks++;
    if (pkt_count !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_ffff got %h exp ffff", pkt_count);
    end
    send_one(1, 32'h6666_0001);
    checks++;
    if (pkt_count !== 16'h0000) begin
      failures++; $display("FAIL wrap_zero got %h exp 0000", pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_hold_off();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_st_pkt_arbiter.md
AVALON_ST_PKT_ARBITER -- requirements
Module: avalon_st_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 4: number of Avalon-ST sink ports.
REQ-002 The block SHALL have parameter DATA_W, default 32: data bits per beat.
REQ-003 The block SHALL have parameter EMPTY_W, default 2: empty field width.
REQ-004 The block SHALL have parameter ERR_W, default 1: error field width.
REQ-005 The block SHALL have parameter CH_W, default 2: channel width, equal to clog2(NUM_IN).
REQ-006 The block SHALL have port clk, input, 1: the single clock; all logic rises on its rising edge.
REQ-007 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, NUM_IN: per-sink valid.
REQ-009 The block SHALL have port in_ready, output, NUM_IN: per-sink ready, READY_LATENCY 0.
REQ-010 The block SHALL have ports in_data (NUM_IN*DATA_W), in_empty (NUM_IN*EMPTY_W) and in_error (NUM_IN*ERR_W), all inputs: flat-packed, sink i occupies slice i.
REQ-011 The block SHALL have ports in_startofpacket and in_endofpacket, input, NUM_IN: per-sink packet delimiters.
REQ-012 The block SHALL have ports out_valid, out_data, out_empty, out_error, out_startofpacket, out_endofpacket, all outputs: the source port.
REQ-013 The block SHALL have port out_ready, input, 1: downstream ready, READY_LATENCY 0.
REQ-014 The block SHALL have port out_channel, output, CH_W: index of the granted sink.
REQ-015 The block SHALL have port pkt_count, output, 16: number of packets forwarded, wrapping.

Function
REQ-016 The arbiter SHALL be a two-state FSM: IDLE, and PKT (grant locked).
REQ-017 In IDLE, out_valid SHALL be 0 and all in_ready SHALL be 0.
REQ-018 In IDLE with any in_valid set, the FSM SHALL register grant_idx, the first set in_valid bit searching upward from rr_ptr with wrap-around, and SHALL enter PKT on the next edge.
REQ-019 In PKT, out_data/empty/error/startofpacket/endofpacket/valid SHALL equal the grant_idx sink's fields combinationally.
REQ-020 In PKT, in_ready[grant_idx] SHALL equal out_ready, and every other in_ready bit SHALL be 0.
REQ-021 out_channel SHALL equal grant_idx in PKT and 0 in IDLE.
REQ-022 Grant SHALL hold from the first beat through the beat where out_valid & out_ready & out_endofpacket.
REQ-023 On that beat, the FSM SHALL return to IDLE, rr_ptr SHALL become (grant_idx+1) mod NUM_IN, and pkt_count SHALL increment, wrapping from 0xFFFF to 0.
REQ-024 A single-beat packet (sop=1, eop=1) SHALL complete in one PKT cycle.
REQ-025 Latency SHALL be one cycle from in_valid seen in IDLE to the first out_valid, with a minimum of one IDLE cycle between packets.
REQ-026 A granted sink whose first beat has sop=0 SHALL be forwarded unchanged; the arbiter does not repair framing.
REQ-027 In PKT, deassertion of in_valid[grant_idx] mid-packet SHALL keep the grant and SHALL drive out_valid 0.
REQ-028 Back-pressure (out_ready=0) SHALL hold the output fields stable as supplied by the granted sink; no beat SHALL be lost or duplicated.
REQ-029 Sinks other than grant_idx SHALL never observe in_ready=1.

Reset
REQ-030 While reset=1 at a clk edge, the FSM SHALL go to IDLE, rr_ptr SHALL be 0, pkt_count SHALL be 0, and grant_idx SHALL be 0.
REQ-031 During and after reset, out_valid SHALL be 0, all in_ready SHALL be 0, and out_channel SHALL be 0.
REQ-032 Reset mid-packet SHALL abandon the packet with no trailing beats forwarded; the next grant SHALL restart arbitration from sink 0.

Verification
REQ-033 A bench SHALL cover: sink 2 sends a 3-beat packet, out_ready=1 -> out_valid in cycles 1..3, out_channel=2, eop on beat 3, pkt_count=1, rr_ptr=3.
REQ-034 A bench SHALL cover: all 4 sinks valid continuously with 1-beat packets -> grant order 0,1,2,3,0, with one IDLE cycle between packets.
REQ-035 A bench SHALL cover: sink 1 is granted, sink 0 asserts valid mid-packet -> in_ready[0] stays 0 until sink 1's eop is accepted, then sink 0 is granted next.
REQ-036 A bench SHALL cover: out_ready=0 for 5 cycles mid-packet -> out_data stable and in_ready[g]=0, with no beat loss once out_ready=1.
REQ-037 A bench SHALL cover: reset=1 during beat 2 of a 4-beat packet -> next cycle out_valid=0 and pkt_count=0, then a new packet from sink 3 is granted.
REQ-038 A bench SHALL cover: pkt_count preloaded via 65536 packets -> value wraps to 0.
